// File: rtl/char_buf_loader.sv
// char_buf_loader: serial command receiver owning the C_COLS x C_ROWS buffer of 5-bit cells.
// Define CHARBUF_DBLBUF_EN for shadow/active double buffering with a frame-synchronous commit.
module char_buf_loader #(
  parameter int unsigned C_COLS = 16,
  parameter int unsigned C_ROWS = 12
) (
  input  logic                         CK_i,
  input  logic                         XARST_i,
  input  logic                         XSS_i,
  input  logic                         SEE_i,
  input  logic                         COPI_i,
  output logic                         CIPO_o,
  input  logic                         FRAME_EE_i,
  output logic [5*C_COLS*C_ROWS-1:0]   DATss_o,
  output logic                         COMMIT_PEND_o,
  output logic                         ERR_o
);

  localparam int unsigned N = C_COLS * C_ROWS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_WR,
    S_FILL,
    S_RD,
    S_CMT,
    S_DROP
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  bit_cnt, bit_cnt_nxt;
  logic [14:0] sr;
  logic [7:0]  addr;
  logic [7:0]  tx;
  logic        err_q;
  logic        pend_q;

  logic        shift_en;
  logic [15:0] hdr_word;
  logic [7:0]  byte_word;
  logic        addr_ok;
  logic        hdr_bad;
  logic        hdr_done;
  logic        byte_done;
  logic        cmt_set;
  logic        wr_en;
  logic        fill_en;
  logic        rd_adv;

  logic [4:0]  act [N];
`ifdef CHARBUF_DBLBUF_EN
  logic [4:0]  shd [N];
`endif

  assign shift_en  = ~XSS_i & SEE_i;
  assign hdr_word  = {sr[14:0], COPI_i};
  assign byte_word = {sr[6:0], COPI_i};
  assign addr_ok   = ({1'b0, hdr_word[7:0]} < 9'(N));
  assign hdr_bad   = ~hdr_word[14] & ~addr_ok;
  assign cmt_set   = hdr_done & (hdr_word[15:14] == 2'b11);
  assign wr_en     = byte_done & (state == S_WR);
  assign fill_en   = byte_done & (state == S_FILL);
  assign rd_adv    = byte_done & (state == S_RD);

  function automatic logic [7:0] addr_inc(input logic [7:0] a);
    if (a == 8'(N - 1)) return '0;
    return a + 8'd1;
  endfunction

  function automatic logic [4:0] rd_cell(input logic [7:0] a);
`ifdef CHARBUF_DBLBUF_EN
    return shd[a];
`else
    return act[a];
`endif
  endfunction

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  // IDLE doubles as header bit 0 so a bit captured on the select edge is not lost.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    hdr_done    = 1'b0;
    byte_done   = 1'b0;
    if (XSS_i) begin
      state_nxt   = S_IDLE;
      bit_cnt_nxt = '0;
    end else begin
      if (state == S_IDLE) state_nxt = S_HDR;
      if (SEE_i) begin
        case (state)
          S_IDLE, S_HDR: begin
            if (bit_cnt == 4'd15) begin
              hdr_done    = 1'b1;
              bit_cnt_nxt = '0;
              case (hdr_word[15:14])
                2'b00:   state_nxt = addr_ok ? S_WR : S_DROP;
                2'b01:   state_nxt = S_FILL;
                2'b10:   state_nxt = addr_ok ? S_RD : S_DROP;
                default: state_nxt = S_CMT;
              endcase
            end else begin
              bit_cnt_nxt = bit_cnt + 4'd1;
            end
          end
          default: begin
            if (bit_cnt == 4'd7) begin
              byte_done   = 1'b1;
              bit_cnt_nxt = '0;
            end else begin
              bit_cnt_nxt = bit_cnt + 4'd1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      sr     <= '0;
      addr   <= '0;
      tx     <= '0;
      err_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      if (XSS_i)         sr <= '0;
      else if (shift_en) sr <= {sr[13:0], COPI_i};

      if (hdr_done) begin
        addr  <= hdr_word[7:0];
        err_q <= hdr_bad;
      end else if (wr_en || rd_adv) begin
        addr <= addr_inc(addr);
      end

      // tx only ever holds data in RD; its MSB is the registered serial output.
      if (XSS_i)
        tx <= '0;
      else if (hdr_done)
        tx <= (state_nxt == S_RD) ? {3'b000, rd_cell(hdr_word[7:0])} : '0;
      else if (state == S_RD && shift_en)
        tx <= byte_done ? {3'b000, rd_cell(addr_inc(addr))} : {tx[6:0], 1'b0};

`ifdef CHARBUF_DBLBUF_EN
      if (cmt_set)         pend_q <= 1'b1;
      else if (FRAME_EE_i) pend_q <= 1'b0;
`else
      pend_q <= cmt_set;
`endif
    end
  end

`ifdef CHARBUF_DBLBUF_EN
  // Copy reads pre-edge shadow, so a coincident write reaches active only at the next commit.
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      for (int unsigned i = 0; i < N; i++) begin
        act[i] <= '0;
        shd[i] <= '0;
      end
    end else begin
      if (FRAME_EE_i && pend_q) begin
        for (int unsigned i = 0; i < N; i++) act[i] <= shd[i];
      end
      if (fill_en) begin
        for (int unsigned i = 0; i < N; i++) shd[i] <= byte_word[4:0];
      end else if (wr_en) begin
        shd[addr] <= byte_word[4:0];
      end
    end
  end
`else
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      for (int unsigned i = 0; i < N; i++) act[i] <= '0;
    end else begin
      if (fill_en) begin
        for (int unsigned i = 0; i < N; i++) act[i] <= byte_word[4:0];
      end else if (wr_en) begin
        act[addr] <= byte_word[4:0];
      end
    end
  end
`endif

  always_comb begin
    DATss_o = '0;
    for (int unsigned i = 0; i < N; i++) DATss_o[5*i +: 5] = act[i];
  end

  assign CIPO_o        = tx[7];
  assign COMMIT_PEND_o = pend_q;
  assign ERR_o         = err_q;

  logic unused_bits;
`ifdef CHARBUF_DBLBUF_EN
  assign unused_bits = ^{hdr_word[13:8], byte_word[7:5]};
`else
  assign unused_bits = ^{hdr_word[13:8], byte_word[7:5], FRAME_EE_i};
`endif

endmodule

// File: tb/tb_char_buf_loader.sv
// Bench for char_buf_loader: transaction-level cell/commit/read model checked every cycle,
// plus literal expectations. Works with or without CHARBUF_DBLBUF_EN.
`timescale 1ns/1ps
module tb_char_buf_loader;

  localparam int unsigned COLS = 16;
  localparam int unsigned ROWS = 12;
  localparam int unsigned N    = COLS * ROWS;

  logic           CK_i = 1'b0;
  logic           XARST_i, XSS_i, SEE_i, COPI_i, FRAME_EE_i;
  logic           CIPO_o, COMMIT_PEND_o, ERR_o;
  logic [5*N-1:0] DATss_o;

  char_buf_loader #(.C_COLS(COLS), .C_ROWS(ROWS)) dut (
    .CK_i(CK_i), .XARST_i(XARST_i), .XSS_i(XSS_i), .SEE_i(SEE_i), .COPI_i(COPI_i),
    .CIPO_o(CIPO_o), .FRAME_EE_i(FRAME_EE_i), .DATss_o(DATss_o),
    .COMMIT_PEND_o(COMMIT_PEND_o), .ERR_o(ERR_o)
  );

  always #5 CK_i = ~CK_i;

  logic [4:0]  m_act [N];
`ifdef CHARBUF_DBLBUF_EN
  logic [4:0]  m_shd [N];
`endif
  logic        m_pend, m_err, m_cipo;
  int unsigned n_chk = 0, n_fail = 0;
  bit          chk_en = 0;
  logic [7:0]  dbytes [8];
  bit          frame_hdr = 0, frame_last = 0;
  logic [7:0]  cap;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, got, exp);
    end
  endtask

  task automatic chk_cell(input string nm, input int unsigned idx, input logic [4:0] exp);
    chk(nm, {3'b000, DATss_o[5*idx +: 5]}, {3'b000, exp});
  endtask

  function automatic logic [4:0] m_src(input logic [7:0] a);
`ifdef CHARBUF_DBLBUF_EN
    return m_shd[a];
`else
    return m_act[a];
`endif
  endfunction

  task automatic m_write(input int unsigned i, input logic [4:0] v);
`ifdef CHARBUF_DBLBUF_EN
    m_shd[i] = v;
`else
    m_act[i] = v;
`endif
  endtask

  function automatic logic [7:0] nxt(input logic [7:0] a);
    return (int'(a) == int'(N) - 1) ? 8'd0 : a + 8'd1;
  endfunction

  task automatic model_reset();
    for (int unsigned i = 0; i < N; i++) begin
      m_act[i] = '0;
`ifdef CHARBUF_DBLBUF_EN
      m_shd[i] = '0;
`endif
    end
    m_pend = 0; m_err = 0; m_cipo = 0;
  endtask

  // One clock edge; applies frame commit (double buffer) or ends the commit pulse.
  task automatic tick();
    bit do_copy;
    do_copy = FRAME_EE_i && m_pend;
    @(posedge CK_i); #1;
`ifdef CHARBUF_DBLBUF_EN
    if (do_copy) begin
      for (int unsigned i = 0; i < N; i++) m_act[i] = m_shd[i];
      m_pend = 0;
    end
`else
    if (do_copy) m_pend = 0;
    m_pend = 0;
`endif
  endtask

  task automatic send_bit(input logic b, input bit fr);
    SEE_i = 1; COPI_i = b; FRAME_EE_i = fr;
    tick();
    SEE_i = 0; COPI_i = 0; FRAME_EE_i = 0;
  endtask

  task automatic txn(input logic [15:0] hdr, input int unsigned nbytes, input int unsigned tail);
    logic [1:0]  cmd;
    logic [7:0]  a, rb;
    bit          ok;
    int unsigned pos, nbits;
    XSS_i = 0; SEE_i = 0;
    tick();
    for (int i = 15; i >= 0; i--) begin
      send_bit(hdr[i], frame_hdr && i == 0);
      if (i == 12) begin COPI_i = 1; tick(); COPI_i = 0; end
    end
    cmd = hdr[15:14]; a = hdr[7:0];
    ok = !(cmd[0] == 1'b0 && int'(a) >= int'(N));
    m_err = !ok;
    if (cmd == 2'b11) m_pend = 1;
    rb = '0; pos = 7;
    if (cmd == 2'b10 && ok) rb = {3'b000, m_src(a)};
    m_cipo = rb[7];
    cap = '0;
    cap[7] = CIPO_o;
    nbits = nbytes * 8 + tail;
    for (int unsigned j = 0; j < nbits; j++) begin
      logic [7:0] db;
      db = dbytes[j/8];
      send_bit(db[7 - (j % 8)], frame_last && (int'(j) == int'(nbytes * 8) - 1));
      if (cmd == 2'b10 && ok) begin
        if (j % 8 == 7) begin a = nxt(a); rb = {3'b000, m_src(a)}; pos = 7; end
        else pos--;
        m_cipo = rb[pos];
        if (j < 7) cap[6 - j] = CIPO_o;
      end
      if (j % 8 == 7 && j / 8 < nbytes) begin
        if (cmd == 2'b00 && ok) begin m_write(a, db[4:0]); a = nxt(a); end
        else if (cmd == 2'b01) for (int unsigned k = 0; k < N; k++) m_write(k, db[4:0]);
      end
    end
    XSS_i = 1;
    tick();
    m_cipo = 0;
    tick();
  endtask

  task automatic publish();
`ifdef CHARBUF_DBLBUF_EN
    txn(16'hC000, 0, 0);
    chk("pub_pend", {7'b0, COMMIT_PEND_o}, 8'h01);
    FRAME_EE_i = 1; tick(); FRAME_EE_i = 0;
`endif
  endtask

  always @(negedge CK_i) begin
    if (chk_en) begin
      int bad;
      bad = -1;
      for (int i = 0; i < int'(N); i++)
        if (bad < 0 && DATss_o[5*i +: 5] !== m_act[i]) bad = i;
      n_chk++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL dat_cell[%0d] @%0t: got %h want %h", bad, $time, DATss_o[5*bad +: 5], m_act[bad]);
      end
      chk("cipo", {7'b0, CIPO_o}, {7'b0, m_cipo});
      chk("pend", {7'b0, COMMIT_PEND_o}, {7'b0, m_pend});
      chk("err",  {7'b0, ERR_o}, {7'b0, m_err});
    end
  end

  initial begin
    XARST_i = 0; XSS_i = 1; SEE_i = 0; COPI_i = 0; FRAME_EE_i = 0;
    model_reset();
    repeat (3) @(posedge CK_i);
    #1;
    chk("rst_dat_any", {7'b0, |DATss_o}, 8'h00);
    chk("rst_cipo", {7'b0, CIPO_o}, 8'h00);
    chk("rst_pend", {7'b0, COMMIT_PEND_o}, 8'h00);
    chk("rst_err",  {7'b0, ERR_o}, 8'h00);
    XARST_i = 1;
    tick();
    chk_en = 1;

    // WRITE at 190 with wrap to 0
    dbytes[0] = 8'h1A; dbytes[1] = 8'h05; dbytes[2] = 8'h13;
    txn(16'h00BE, 3, 0);
`ifdef CHARBUF_DBLBUF_EN
    chk_cell("wr_hidden190", 190, 5'h00);
`endif
    publish();
    chk_cell("wr_cell190", 190, 5'h1A);
    chk_cell("wr_cell191", 191, 5'h05);
    chk_cell("wr_cell0",   0,   5'h13);

    // FILL then COMMIT + frame strobe
    dbytes[0] = 8'h1F;
    txn(16'h4000, 1, 0);
    txn(16'hC000, 0, 0);
`ifdef CHARBUF_DBLBUF_EN
    chk("fill_pend_set", {7'b0, COMMIT_PEND_o}, 8'h01);
`endif
    FRAME_EE_i = 1; tick(); FRAME_EE_i = 0;
    chk("fill_pend_clr", {7'b0, COMMIT_PEND_o}, 8'h00);
    begin
      int nbad;
      nbad = 0;
      for (int unsigned i = 0; i < N; i++) if (DATss_o[5*i +: 5] !== 5'h1F) nbad++;
      chk("fill_all_1f_badcount", nbad[7:0], 8'h00);
    end

    // READ from 0, two bytes
    dbytes[0] = 8'h00; dbytes[1] = 8'h00;
    txn(16'h8000, 2, 0);
    chk("rd_byte0", cap, 8'h1F);
    chk("rd_idle_cipo", {7'b0, CIPO_o}, 8'h00);
    txn(16'h80BF, 2, 0);
    chk("rd_byte191", cap, 8'h1F);

    // bad addresses
    dbytes[0] = 8'h15;
    txn(16'h00C8, 1, 0);
    chk("err_wr200", {7'b0, ERR_o}, 8'h01);
    txn(16'h80C0, 1, 0);
    chk("err_rd192", {7'b0, ERR_o}, 8'h01);
    chk("err_rd_cipo", {7'b0, CIPO_o}, 8'h00);
    txn(16'h8005, 0, 0);
    chk("err_cleared", {7'b0, ERR_o}, 8'h00);

    // abort after 5 data bits, then a fresh header
    dbytes[0] = 8'h0A;
    txn(16'h000A, 0, 5);
    dbytes[0] = 8'h07;
    txn(16'h000B, 1, 0);
    publish();
    chk_cell("abort_cell10", 10, 5'h1F);
    chk_cell("abort_cell11", 11, 5'h07);

    // frame strobe on the header-completion cycle of COMMIT
    dbytes[0] = 8'h12;
    txn(16'h0003, 1, 0);
    frame_hdr = 1;
    txn(16'hC000, 0, 0);
    frame_hdr = 0;
`ifdef CHARBUF_DBLBUF_EN
    chk("coinc_pend", {7'b0, COMMIT_PEND_o}, 8'h01);
    chk_cell("coinc_cell3_old", 3, 5'h1F);
`else
    chk("coinc_pend", {7'b0, COMMIT_PEND_o}, 8'h00);
`endif
    FRAME_EE_i = 1; tick(); FRAME_EE_i = 0;
    chk_cell("coinc_cell3_new", 3, 5'h12);

    // shadow write coinciding with the copy
    txn(16'hC000, 0, 0);
    dbytes[0] = 8'h09;
    frame_last = 1;
    txn(16'h0004, 1, 0);
    frame_last = 0;
`ifdef CHARBUF_DBLBUF_EN
    chk_cell("copywr_cell4_pre", 4, 5'h1F);
    chk("copywr_pend", {7'b0, COMMIT_PEND_o}, 8'h00);
`endif
    publish();
    chk_cell("copywr_cell4_post", 4, 5'h09);

    // asynchronous reset mid-transaction
    txn(16'h00C8, 0, 0);
    txn(16'hC000, 0, 0);
    XSS_i = 0; tick();
    send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
    chk_en = 0;
    #2 XARST_i = 0;
    #1;
    chk("mid_rst_dat_any", {7'b0, |DATss_o}, 8'h00);
    chk("mid_rst_err",  {7'b0, ERR_o}, 8'h00);
    chk("mid_rst_pend", {7'b0, COMMIT_PEND_o}, 8'h00);
    chk("mid_rst_cipo", {7'b0, CIPO_o}, 8'h00);
    model_reset();
    XSS_i = 1; SEE_i = 0;
    @(posedge CK_i); #1;
    XARST_i = 1;
    @(posedge CK_i); #1;
    chk_en = 1;
    dbytes[0] = 8'h05;
    txn(16'h0000, 1, 0);
    publish();
    chk_cell("post_rst_cell0", 0, 5'h05);
    chk_cell("post_rst_cell1", 1, 5'h00);

    repeat (2) tick();
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/char_buf_loader.md
# char_buf_loader

Serial command receiver that owns the 16x12 character-cell buffer consumed by the 5x7 font renderer. A host clocks framed commands in over a select/data/bit-enable link and writes, fills or reads 5-bit cells (DISP_ON + 4-bit hex code). With double buffering compiled in, the writes land in a shadow copy, and a committed image is swapped into the renderer-facing output only on a frame strobe, so the display never tears.

## Interface
- C_COLS, 16, cells per row
- C_ROWS, 12, rows; C_COLS*C_ROWS must be ≤ 256
- CK_i  in  1  system clock
- XARST_i  in  1  asynchronous active-low reset
- XSS_i  in  1  active-low select; high = idle/abort
- SEE_i  in  1  bit-enable; COPI_i sampled on CK_i when SEE_i=1 and XSS_i=0
- COPI_i  in  1  serial data in, MSB first
- CIPO_o  out  1  serial data out (read command), registered
- FRAME_EE_i  in  1  one-cycle frame strobe (vertical blank start)
- DATss_o  out  5*C_COLS*C_ROWS  cell n at [5n+4:5n]; bit 4 = DISP_ON, [3:0] = hex
- COMMIT_PEND_o  out  1  commit requested, not yet applied
- ERR_o  out  1  sticky bad-address flag; cleared by next valid header

## Operation
- Transaction = XSS_i low period. The 16-bit header is followed by 8-bit data bytes, with a bit counter of 0..15, then 0..7 repeating.
- Header: [15:14] CMD, [13:8] ignored, [7:0] ADDR = row*C_COLS+col.
- Supported commands:
  - CMD 00 WRITE: each complete byte writes [4:0] to cell ADDR; [7:5] are ignored. ADDR then increments and wraps from C_COLS*C_ROWS-1 to 0.
  - CMD 01 FILL: the first complete byte writes [4:0] to every cell in one cycle. Later bytes repeat the fill.
  - CMD 10 READ: CIPO_o streams {3'b000, cell[ADDR]} MSB first, one byte per cell, with ADDR auto-increment and wrap. It reads the shadow copy (the active copy without the macro).
  - CMD 11 COMMIT: completing the header sets COMMIT_PEND_o. Any data bytes that follow are ignored.
- ADDR ≥ C_COLS*C_ROWS with CMD 00 or 10: ERR_o=1, and all data in that transaction is ignored. CIPO_o stays 0.
- FSM states:
  - IDLE → HDR on XSS_i falling.
  - HDR → WR / FILL / RD / CMT / DROP after bit 15.
  - Any state → IDLE when XSS_i=1. The partial byte is discarded and counters clear.
- SEE_i is ignored while XSS_i=1. While XSS_i=0 and SEE_i=0, all state holds.

## Timing
- Reset values:
  - DATss_o=0 (and shadow=0)
  - CIPO_o=0, COMMIT_PEND_o=0, ERR_o=0
  - FSM=IDLE
- Write/fill: the cell register updates on the CK_i edge after the SEE_i cycle that captured bit 0 of the byte, i.e. 1-cycle latency.
- Read:
  - The byte MSB is on CIPO_o the cycle after the SEE_i that captured header bit 0.
  - Each SEE_i shifts one bit.
  - The cycle after the 8th SEE_i, the next cell's MSB is loaded.
  - CIPO_o=0 in all non-READ states and the cycle after XSS_i rises.
- Commit:
  - On FRAME_EE_i with COMMIT_PEND_o=1, DATss_o←shadow and COMMIT_PEND_o←0, both on the next edge.
  - If FRAME_EE_i coincides with the header-completion cycle, PEND is set, and the copy happens only on the following FRAME_EE_i.
  - If a shadow write coincides with the copy, DATss_o gets the pre-write shadow and the shadow gets the new value.
  - A second COMMIT while pending has no extra effect.
- XSS_i abort does not clear COMMIT_PEND_o or ERR_o.
- A reset mid-transaction returns everything to reset values immediately (asynchronous).

## Configuration
- CHARBUF_DBLBUF_EN defined: shadow + active buffers, commit behaviour as above.
- Undefined:
  - No shadow; writes and fills update DATss_o directly with 1-cycle latency.
  - COMMIT only pulses COMMIT_PEND_o high for one cycle.
  - FRAME_EE_i is ignored.

## Test plan
- Reset → DATss_o=0, CIPO_o=0, COMMIT_PEND_o=0, ERR_o=0.
- WRITE ADDR=190, bytes 0x1A,0x05,0x13 → cell190=5'h1A, cell191=5'h05, cell0=5'h13 (wrap). With the macro, DATss_o stays 0 until COMMIT + FRAME_EE_i.
- FILL byte 0x1F, COMMIT, FRAME_EE_i → COMMIT_PEND_o 1→0, and all 192 cells of DATss_o equal 5'h1F the cycle after the strobe.
- READ ADDR=0 after the fill → CIPO_o bits 0,0,0,1,1,1,1,1 per byte. After XSS_i rises, CIPO_o=0.
- WRITE ADDR=200 → ERR_o=1, no cell changes. Next valid header → ERR_o=0.
- XSS_i raised after 5 data bits → no write. A new transaction's header is decoded correctly from bit 15.
